// File: rtl/bridge_pkg.sv
// Shared types and sizing for the bridge sequencing controller.
// The block size follows from the bridge word and byte widths.
package bridge_pkg;

  localparam int BRIDGE_WIDTH    = 528;
  localparam int BYTE_WIDTH      = 8;
  localparam int BYTES_PER_BLOCK = BRIDGE_WIDTH / BYTE_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    SETTLE,
    HOLD
  } state_e;

endpackage

// File: rtl/bridge_timeout_cnt.sv
// Saturating idle-cycle counter for the partial-block timeout.
// expired_o flags the cycle whose idle edge would reach LIMIT.
module bridge_timeout_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] LIM    = TW'(LIMIT);
  localparam logic [TW-1:0] LIM_M1 = TW'(LIMIT - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Clear wins over count; hold at LIMIT instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= LIM_M1);

endmodule

// File: rtl/bridge_ctrl.sv
// Sequencer feeding bytes into the bridge shift register and
// handing the completed (possibly zero-padded) word downstream.
module bridge_ctrl #(
  parameter int          BYTES_PER_BLOCK = bridge_pkg::BYTES_PER_BLOCK,
  parameter int          TIMEOUT_CYCLES  = 1024,
  parameter logic [7:0]  PAD_BYTE        = 8'h00
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       shift_en,
  output logic [7:0] data_out,
  output logic       block_valid,
  input  logic       block_ready,
  output logic       block_padded,
  output logic [$clog2(BYTES_PER_BLOCK+1)-1:0] byte_count
);

  import bridge_pkg::*;

  localparam int CW = $clog2(BYTES_PER_BLOCK + 1);
  localparam logic [CW-1:0] LAST = CW'(BYTES_PER_BLOCK - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          bvalid_q, bvalid_d;
  logic          padded_q, padded_d;

  logic accept;
  logic at_last;
  logic expired;
  logic tmr_clr;
  logic tmr_en;

  assign byte_ready = (state_q == IDLE) || (state_q == FILL);
  assign accept     = byte_valid && byte_ready;
  assign at_last    = (count_q == LAST);

  // Timer only runs while a partial block waits for more bytes.
  assign tmr_clr = (state_q != FILL) || accept;
  assign tmr_en  = (state_q == FILL) && !accept;

  bridge_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmr (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (expired)
  );

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shift_q  <= 1'b0;
      data_q   <= 8'h00;
      bvalid_q <= 1'b0;
      padded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      bvalid_q <= bvalid_d;
      padded_q <= padded_d;
    end
  end

  // Next state; acceptance beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = at_last ? SETTLE : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          if (at_last) begin
            state_d = SETTLE;
          end
        end else if (expired) begin
          state_d = PAD;
        end
      end
      PAD: begin
        if (at_last) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (bvalid_q && block_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of shift strobe, data, count and block flags.
  always_comb begin
    shift_d  = 1'b0;
    data_d   = data_q;
    count_d  = count_q;
    bvalid_d = bvalid_q;
    padded_d = padded_q;
    if (accept) begin
      shift_d = 1'b1;
      data_d  = byte_in;
      count_d = count_q + 1'b1;
    end
    if (state_q == PAD) begin
      shift_d = 1'b1;
      data_d  = PAD_BYTE;
      count_d = count_q + 1'b1;
    end
    if ((state_q == FILL) && !accept && expired) begin
      padded_d = 1'b1;
    end
    if ((state_q == SETTLE) && (state_d == HOLD)) begin
      bvalid_d = 1'b1;
    end
    if ((state_q == HOLD) && (state_d == IDLE)) begin
      count_d  = '0;
      bvalid_d = 1'b0;
      padded_d = 1'b0;
    end
  end

  assign shift_en     = shift_q;
  assign data_out     = data_q;
  assign block_valid  = bvalid_q;
  assign block_padded = padded_q;
  assign byte_count   = count_q;

endmodule

// File: tb/tb_bridge_ctrl.sv
// Directed bench for bridge_ctrl with a behavioural bridge
// shift register; timeout shortened to 16 cycles.
module tb_bridge_ctrl;

  import bridge_pkg::*;

  localparam int BPB = BYTES_PER_BLOCK;
  localparam int CW  = $clog2(BPB + 1);
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          shift_en;
  logic [7:0]    data_out;
  logic          block_valid;
  logic          block_ready = 1'b0;
  logic          block_padded;
  logic [CW-1:0] byte_count;

  logic [BRIDGE_WIDTH-1:0] word = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bridge_ctrl #(
    .BYTES_PER_BLOCK (BPB),
    .TIMEOUT_CYCLES  (TMO),
    .PAD_BYTE        (8'h00)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .shift_en     (shift_en),
    .data_out     (data_out),
    .block_valid  (block_valid),
    .block_ready  (block_ready),
    .block_padded (block_padded),
    .byte_count   (byte_count)
  );

  // Model of the bridge: shares reset, shifts in at the LSB end.
  always @(posedge clk) begin
    if (!n_rst) begin
      word <= '0;
    end else if (shift_en) begin
      word <= {word[BRIDGE_WIDTH-9:0], data_out};
    end
  end

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send n bytes back to back; count cycles lacking the shift.
  task automatic send(input int n, input logic [7:0] first,
                      input bit incr, output int bad);
    logic [7:0] b;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      b = incr ? first + 8'(i) : first;
      byte_in    = b;
      byte_valid = 1'b1;
      @(negedge clk);
      if (shift_en !== 1'b1 || data_out !== b) bad++;
    end
    byte_valid = 1'b0;
  endtask

  task automatic release_block();
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  int bad;
  int first_sh;
  int n_pad;
  int bad_pad;
  int t_valid;
  int bad_bp;
  int bad_rc;

  initial begin
    @(negedge clk);
    do_reset();

    check("rst_ready", byte_ready, 1);
    check("rst_shift", shift_en, 0);
    check("rst_data", data_out, 0);
    check("rst_valid", block_valid, 0);
    check("rst_padded", block_padded, 0);
    check("rst_count", byte_count, 0);

    // Full block 0x01..0x42.
    send(BPB, 8'h01, 1'b1, bad);
    check("fill_shifts", bad, 0);
    check("fill_count", byte_count, BPB);
    check("fill_valid_early", block_valid, 0);
    @(negedge clk);
    check("fill_valid", block_valid, 1);
    check("fill_padded", block_padded, 0);
    check("fill_word", word[15:0], 16'h4142);

    // Backpressure in HOLD.
    byte_valid = 1'b1;
    byte_in    = 8'hEE;
    bad_bp     = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (byte_ready !== 1'b0) bad_bp++;
      if (shift_en !== 1'b0) bad_bp++;
      if (block_valid !== 1'b1) bad_bp++;
    end
    check("bp_hold", bad_bp, 0);
    check("bp_word", word[15:0], 16'h4142);
    release_block();
    byte_valid = 1'b0;
    check("bp_ready", byte_ready, 1);
    check("bp_count", byte_count, 0);
    check("bp_valid", block_valid, 0);

    // Partial block then timeout padding.
    send(10, 8'hA5, 1'b0, bad);
    check("pad_send", bad, 0);
    check("pad_count10", byte_count, 10);
    first_sh = 0;
    n_pad    = 0;
    bad_pad  = 0;
    t_valid  = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (shift_en) begin
        if (first_sh == 0) first_sh = c;
        n_pad++;
        if (data_out !== 8'h00) bad_pad++;
        if (byte_ready !== 1'b0) bad_pad++;
      end
      if (block_valid) begin
        t_valid = c;
        break;
      end
    end
    check("pad_first", first_sh, TMO + 1);
    check("pad_shifts", n_pad, BPB - 10);
    check("pad_bytes", bad_pad, 0);
    check("pad_valid_t", t_valid, TMO + 1 + BPB - 10);
    check("pad_padded", block_padded, 1);
    check("pad_count", byte_count, BPB);
    check("pad_word_hi", word[BRIDGE_WIDTH-1 -: 80],
          {10{8'hA5}});
    check("pad_word_lo", word[447:0] == '0, 1);
    release_block();
    check("pad_clr_padded", block_padded, 0);

    // Acceptance on the expiring idle cycle.
    send(3, 8'h10, 1'b1, bad);
    check("race_send", bad, 0);
    repeat (TMO - 1) @(negedge clk);
    check("race_wait", byte_ready, 1);
    byte_in    = 8'h77;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    check("race_shift", {shift_en, data_out}, {1'b1, 8'h77});
    check("race_count", byte_count, 4);
    check("race_nopad", {byte_ready, block_padded}, 2'b10);
    bad_rc = 0;
    for (int i = 0; i < TMO - 1; i++) begin
      @(negedge clk);
      if (shift_en !== 1'b0 || byte_ready !== 1'b1) bad_rc++;
    end
    check("race_restart", bad_rc, 0);
    @(negedge clk);
    check("race_pad_late", {byte_ready, block_padded}, 2'b01);

    // Reset aborts a padding block.
    do_reset();
    check("rst2_count", byte_count, 0);

    // Reset mid-fill.
    send(20, 8'h30, 1'b1, bad);
    check("mid_send", bad, 0);
    check("mid_count", byte_count, 20);
    do_reset();
    check("mid_outs",
          {byte_ready, shift_en, data_out, block_valid, block_padded},
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    check("mid_count0", byte_count, 0);
    check("mid_word0", word == '0, 1);
    send(2, 8'hC1, 1'b1, bad);
    check("mid_resend", bad, 0);
    check("mid_count2", byte_count, 2);
    @(negedge clk);
    check("mid_word", word[23:0], 24'h00C1C2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
